// File: rtl/pipe_cla_adder_if.sv
// pipe_cla_adder_if: operand/result handshake bundle for the pipelined lookahead adder
interface pipe_cla_adder_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    modport master (
        output in_valid, a_in, b_in, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );
    modport slave (
        input  in_valid, a_in, b_in, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: pipelined add/sub, one 4-bit lookahead group resolved per stage
module pipe_cla_adder #(
    parameter int WIDTH = 16
) (
    input logic clk,
    input logic rst_n,
    pipe_cla_adder_if.slave bus
);
    localparam int N = WIDTH / 4;

    logic             adv;
    logic [WIDTH-1:0] b_eff;

    assign adv = !bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv;
    assign b_eff = bus.sub ? ~bus.b_in : bus.b_in;

    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p = a ^ b;
        g = a & b;
        c[0] = ci;
        c[1] = g[0] | p[0] & ci;
        c[2] = g[1] | p[1] & g[0] | p[1] & p[0] & ci;
        c[3] = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & ci;
        c[4] = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0]
             | p[3] & p[2] & p[1] & p[0] & ci;
        return {c[4], p ^ c[3:0]};
    endfunction

    for (genvar k = 0; k < N; k++) begin : g_stage
        logic [3:0]     ga;
        logic [3:0]     gb;
        logic           ci;
        logic           vi;
        logic [4:0]     r;
        logic [4*k+3:0] s_n;
        logic [4*k+3:0] s_q;
        logic           c_q;
        logic           v_q;

        if (k == 0) begin : g_in
            assign ga  = bus.a_in[3:0];
            assign gb  = b_eff[3:0];
            assign ci  = bus.sub | bus.c_in;
            assign vi  = bus.in_valid;
            assign s_n = r[3:0];
        end else begin : g_in
            assign ga  = g_stage[k-1].g_fwd.a_q[3:0];
            assign gb  = g_stage[k-1].g_fwd.b_q[3:0];
            assign ci  = g_stage[k-1].c_q;
            assign vi  = g_stage[k-1].v_q;
            assign s_n = {r[3:0], g_stage[k-1].s_q};
        end

        assign r = cla4(ga, gb, ci);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= vi;
                if (vi) begin
                    c_q <= r[4];
                    s_q <= s_n;
                end
            end
        end

        // Only the not-yet-summed upper operand bits travel forward.
        if (k < N - 1) begin : g_fwd
            localparam int R = WIDTH - 4 * (k + 1);
            logic [R-1:0] a_n;
            logic [R-1:0] b_n;
            logic [R-1:0] a_q;
            logic [R-1:0] b_q;
            if (k == 0) begin : g_src
                assign a_n = bus.a_in[WIDTH-1:4];
                assign b_n = b_eff[WIDTH-1:4];
            end else begin : g_src
                assign a_n = g_stage[k-1].g_fwd.a_q[R+3:4];
                assign b_n = g_stage[k-1].g_fwd.b_q[R+3:4];
            end
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && vi) begin
                    a_q <= a_n;
                    b_q <= b_n;
                end
            end
        end else begin : g_last
            logic ovf_q;
            // Carry into the MSB is recovered as sum ^ a ^ b_eff of that bit.
            always_ff @(posedge clk) begin
                if (!rst_n)
                    ovf_q <= 1'b0;
                else if (adv && vi)
                    ovf_q <= r[4] ^ (r[3] ^ ga[3] ^ gb[3]);
            end
            assign bus.sum       = s_q;
            assign bus.c_out     = c_q;
            assign bus.ovf       = ovf_q;
            assign bus.out_valid = v_q;
        end
    end
endmodule
